// File: rtl/key_event_fifo.sv
// -----------------------------------------------------------------------------
// key_event_fifo
//
// Turns the debounced, active-low key vector into a stream of press/release
// events. The block scans one key per clock and compares it with a stored
// snapshot. Each difference becomes an event byte, which is pushed into a
// small registered FIFO. The host-interface logic drains that FIFO through a
// valid/ready handshake. If the FIFO is full, the scanner waits on the key
// that changed, so no net change is lost.
//
// Event byte: bit7 = 1 for press / 0 for release, bits6:0 = key index.
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous, active-high reset
//   keys_i       [KEYS] debounced key states, 1 = released, 0 = pressed
//   evt_data_o   [8] head event, taken straight from FIFO storage
//   evt_valid_o  FIFO non-empty
//   evt_ready_i  consumer takes the head event when high with evt_valid_o
//   evt_count_o  [$clog2(DEPTH)+1] current FIFO occupancy
//   fifo_full_o  occupancy == DEPTH
// -----------------------------------------------------------------------------
module key_event_fifo #(
  parameter int KEYS  = 61,  // 1..128
  parameter int DEPTH = 16,  // power of 2, >= 2
  parameter int IDX_W = 7    // key-index field of the event byte
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [KEYS-1:0]            keys_i,
  output logic [7:0]                 evt_data_o,
  output logic                       evt_valid_o,
  input  logic                       evt_ready_i,
  output logic [$clog2(DEPTH):0]     evt_count_o,
  output logic                       fifo_full_o
);

  localparam int SCAN_W = (KEYS > 1) ? $clog2(KEYS) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // State
  logic [KEYS-1:0]   snap_q,   snap_d;
  logic [SCAN_W-1:0] idx_q,    idx_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q,  count_d;
  logic [7:0]        mem_q [DEPTH];

  // Scan / handshake decode
  logic       key_now;
  logic       changed;
  logic       full;
  logic       push;
  logic       pop;
  logic       advance;
  logic [7:0] evt_word;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first. If any
    // path skipped a signal, synthesis would infer a latch.
    key_now  = keys_i[idx_q];
    changed  = (key_now != snap_q[idx_q]);
    full     = (count_q == CNT_W'(DEPTH));
    // The push decision uses only the registered count. A pop in the same
    // cycle does not free a slot for this push.
    push     = changed && !full;
    pop      = (count_q != '0) && evt_ready_i;
    // Stall on an unreported change. A key that returned to its snapshot
    // value reads as unchanged, so the scanner moves on with no event.
    advance  = !changed || push;
    evt_word = {~key_now, IDX_W'(idx_q)};

    idx_d    = idx_q;
    snap_d   = snap_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (advance) begin
      idx_d = (idx_q == SCAN_W'(KEYS - 1)) ? '0 : idx_q + SCAN_W'(1);
    end

    if (push) begin
      snap_d[idx_q] = key_now;
      wr_ptr_d      = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // A push and a pop in the same cycle cancel in the count.
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. The new
  // values then take effect together at the clock edge, regardless of
  // the order of the statements.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap_q   <= '1;  // all released, which matches the debouncer reset
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      snap_q   <= snap_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is normally left unreset. Here it is cleared because the
  // head byte is read combinationally and must read 8'h00 out of reset. The
  // array is only DEPTH bytes, so the extra reset cost is small.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= evt_word;
    end
  end

  // A new entry never overwrites the head: the FIFO is non-empty and not
  // full, so wr_ptr differs from rd_ptr. The head byte therefore holds
  // steady while the consumer stalls.
  assign evt_data_o  = mem_q[rd_ptr_q];
  assign evt_valid_o = (count_q != '0);
  assign evt_count_o = count_q;
  assign fifo_full_o = full;

endmodule

// File: tb/tb_key_event_fifo.sv
// -----------------------------------------------------------------------------
// tb_key_event_fifo
//
// Directed testbench for key_event_fifo at its default parameters
// (61 keys, 16-entry FIFO). Inputs are driven on the falling edge, and
// outputs are sampled on the falling edge. Expected event bytes are
// worked out by hand from the scan order.
// -----------------------------------------------------------------------------
module tb_key_event_fifo;

  localparam int KEYS  = 61;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [KEYS-1:0]  keys_i;
  logic [7:0]       evt_data_o;
  logic             evt_valid_o;
  logic             evt_ready_i;
  logic [CNT_W-1:0] evt_count_o;
  logic             fifo_full_o;

  int errors = 0;
  int checks = 0;
  logic [7:0] got_q [$];

  always #5 clk_i = ~clk_i;

  key_event_fifo #(.KEYS(KEYS), .DEPTH(DEPTH), .IDX_W(7)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .keys_i      (keys_i),
    .evt_data_o  (evt_data_o),
    .evt_valid_o (evt_valid_o),
    .evt_ready_i (evt_ready_i),
    .evt_count_o (evt_count_o),
    .fifo_full_o (fifo_full_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reset ends on a falling edge with rst_i low. The next rising edge
  // scans index 0, so after N more falling edges the scan index is N.
  task automatic do_reset();
    @(negedge clk_i);
    rst_i       = 1'b1;
    evt_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!evt_valid_o && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_seen"}, 32'(evt_valid_o), 32'd1);
  endtask

  // Check the head byte, then take it with a single-cycle ready pulse.
  task automatic pop_one(input string tag, input logic [7:0] exp);
    check(tag, 32'(evt_data_o), 32'(exp));
    evt_ready_i = 1'b1;
    @(negedge clk_i);
    evt_ready_i = 1'b0;
  endtask

  // Hold ready high for a fixed window and record every delivered byte.
  task automatic drain(input int cycles);
    got_q.delete();
    evt_ready_i = 1'b1;
    repeat (cycles) begin
      if (evt_valid_o) got_q.push_back(evt_data_o);
      @(negedge clk_i);
    end
    evt_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int bad;

    // Reset values, taken before any clock edge.
    rst_i       = 1'b1;
    keys_i      = '1;
    evt_ready_i = 1'b0;
    #1;
    check("rst_valid", 32'(evt_valid_o), 32'd0);
    check("rst_count", 32'(evt_count_o), 32'd0);
    check("rst_data",  32'(evt_data_o),  32'h00);
    check("rst_full",  32'(fifo_full_o), 32'd0);

    // 1) Async reset mid-sweep with 3 events queued, then a quiet bus.
    do_reset();
    keys_i[2:0] = '0;
    repeat (10) @(negedge clk_i);
    check("t1_queued", 32'(evt_count_o), 32'd3);
    #2 rst_i = 1'b1;
    #1;
    check("t1_async_valid", 32'(evt_valid_o), 32'd0);
    check("t1_async_count", 32'(evt_count_o), 32'd0);
    check("t1_async_data",  32'(evt_data_o),  32'h00);
    keys_i = '1;
    @(negedge clk_i);
    rst_i = 1'b0;
    seen = 0;
    repeat (200) begin
      @(negedge clk_i);
      if (evt_valid_o) seen++;
    end
    check("t1_quiet", 32'(seen), 32'd0);

    // 2) Single press on key 5 with the consumer stalled, then its release.
    keys_i = '1;
    do_reset();
    keys_i[5] = 1'b0;
    wait_valid("t2_press", 62);
    check("t2_data",  32'(evt_data_o),  32'h85);
    check("t2_count", 32'(evt_count_o), 32'd1);
    repeat (70) @(negedge clk_i);
    check("t2_no_more", 32'(evt_count_o), 32'd1);
    check("t2_stable",  32'(evt_data_o),  32'h85);
    keys_i[5] = 1'b1;
    pop_one("t2_pop_press", 8'h85);
    wait_valid("t2_release", 62);
    pop_one("t2_pop_release", 8'h05);
    check("t2_empty", 32'(evt_count_o), 32'd0);

    // 3) Keys 60 and 0 pressed together while the scan is at index 30.
    keys_i = '1;
    do_reset();
    repeat (30) @(negedge clk_i);
    keys_i[60] = 1'b0;
    keys_i[0]  = 1'b0;
    repeat (70) @(negedge clk_i);
    check("t3_count", 32'(evt_count_o), 32'd2);
    pop_one("t3_first",  8'hBC);
    pop_one("t3_second", 8'h80);

    // 4) Twenty presses overflow the FIFO; the scanner stalls and then resumes.
    keys_i = '1;
    do_reset();
    keys_i[19:0] = '0;
    repeat (40) @(negedge clk_i);
    check("t4_count_sat", 32'(evt_count_o), 32'd16);
    check("t4_full",      32'(fifo_full_o), 32'd1);
    check("t4_head",      32'(evt_data_o),  32'h80);
    drain(100);
    check("t4_total", 32'(got_q.size()), 32'd20);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("t4_evt%0d", i),
            32'((i < got_q.size()) ? got_q[i] : 8'hxx), 32'(8'h80 + i));
    end
    check("t4_empty",    32'(evt_count_o), 32'd0);
    check("t4_not_full", 32'(fifo_full_o), 32'd0);

    // 5) Every key changes on every sweep with ready held high. Push and
    //    pop coincide, so occupancy holds at 1.
    keys_i = '1;
    do_reset();
    keys_i      = '0;
    evt_ready_i = 1'b1;
    bad = 0;
    for (int c = 0; c < 2 * KEYS; c++) begin
      @(negedge clk_i);
      if (evt_count_o != 1 || !evt_valid_o) bad++;
      check($sformatf("t5_evt%0d", c), 32'(evt_data_o),
            (c < KEYS) ? 32'(8'h80 + c) : 32'(c - KEYS));
      if (c == KEYS - 1) keys_i = '1;
    end
    @(negedge clk_i);
    evt_ready_i = 1'b0;
    check("t5_count_const", 32'(bad), 32'd0);
    check("t5_drained",     32'(evt_count_o), 32'd0);

    // 6) Stalled on key 16 while full; key 16 is released before space frees.
    keys_i = '1;
    do_reset();
    keys_i[16:0] = '0;
    repeat (40) @(negedge clk_i);
    check("t6_full", 32'(fifo_full_o), 32'd1);
    keys_i[16] = 1'b1;
    repeat (5) @(negedge clk_i);
    check("t6_count_hold", 32'(evt_count_o), 32'd16);
    drain(60);
    check("t6_total", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t6_evt%0d", i),
            32'((i < got_q.size()) ? got_q[i] : 8'hxx), 32'(8'h80 + i));
    end
    keys_i[20] = 1'b0;
    wait_valid("t6_resume", 62);
    pop_one("t6_key20", 8'h94);
    check("t6_empty", 32'(evt_count_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_event_fifo.md
Name: key_event_fifo

Overview:
- Sits directly downstream of the key debouncer and consumes its debounced, active-low key vector (1 = released, 0 = pressed).
- Scans the vector one key per clock and compares each key with a stored snapshot; each change is encoded as a press or release event.
- Events are buffered in a small FIFO and drained by the host-interface logic through a valid/ready handshake.
- No change is lost while the FIFO has room; when the FIFO is full, scanning stalls.

Parameters:
KEYS, 61, number of keys scanned; 1..128
DEPTH, 16, FIFO depth in events; power of 2, >= 2
IDX_W, 7, key-index field width in the event byte; fixed

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous, active-high reset
keys_i  input  KEYS  debounced key states, active-low, synchronous to clk_i
evt_data_o  output  8  head event: bit7 = 1 press / 0 release, bits6:0 = key index
evt_valid_o  output  1  FIFO non-empty; evt_data_o is valid
evt_ready_i  input  1  consumer accepts the head event when high together with evt_valid_o
evt_count_o  output  $clog2(DEPTH)+1  current FIFO occupancy
fifo_full_o  output  1  occupancy == DEPTH

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (async assert, sync-to-clock use after deassert):
  - snapshot = all ones (all released, matching debouncer reset)
  - scan index = 0; read and write pointers = 0; count = 0
  - evt_valid_o = 0, fifo_full_o = 0, evt_count_o = 0, evt_data_o = 8'h00
- Scan, every cycle, at current index i:
  - keys_i[i] == snap[i]: no push; i advances.
  - keys_i[i] != snap[i] and count < DEPTH: push event {~keys_i[i], i[6:0]}; snap[i] <= keys_i[i]; i advances.
  - keys_i[i] != snap[i] and count == DEPTH: stall. No push, snap[i] and i hold. The comparison is retried every cycle.
  - A pop in the same cycle does not unblock the push. Push eligibility uses the registered count only.
  - If the key returns to its snapshot value while stalled, no event is produced. Only the net state is reported.
- Index advance: i = KEYS-1 wraps to 0. Full sweep = KEYS cycles when not stalled.
- Latency:
  - Change on key i is detected within KEYS cycles.
  - The event appears on evt_valid_o/evt_data_o the cycle after the push, even if the FIFO was empty (no bypass).
- FIFO:
  - Storage is registered. evt_data_o = mem[rd_ptr], combinational from storage. evt_valid_o = (count != 0).
  - Pop occurs when evt_valid_o && evt_ready_i.
  - evt_ready_i while empty: no effect.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers are $clog2(DEPTH) bits and wrap naturally. Count is one bit wider.
- Event ordering: events are written in scan order, so changes detected in one sweep emerge in ascending index order starting from the index at detection time.
- evt_data_o must remain stable while evt_valid_o=1 and evt_ready_i=0.
- Reset mid-operation: all events are discarded and the snapshot returns to all-released. Keys still held after reset generate press events on the next sweep.

Test Plan:
- Reset asserted asynchronously mid-sweep with 3 events queued -> outputs clear immediately without a clock: evt_valid_o=0, evt_count_o=0; after release, all keys high yields no events for 200 cycles.
- keys_i[5]=0 with evt_ready_i=0 -> within 62 cycles evt_valid_o=1, evt_data_o=8'h85, count=1 and no further events; then keys_i[5]=1, drain with ready=1 -> next event 8'h05.
- keys 60 and 0 pressed in the same cycle while scan index is 30 -> events 8'hBC then 8'h80, in that order.
- Keys 0..19 pressed, evt_ready_i=0 -> count saturates at 16, fifo_full_o=1, events 8'h80..8'h8F queued, scanner stalls at index 16; then ready=1 continuously -> 20 events total, 8'h80..8'h93 ascending, none duplicated or lost.
- Continuous key toggling with ready=1 every cycle -> push/pop coincide, count stays constant, every change is reflected in the delivered events.
- Full FIFO stalled on key 16; key 16 released before space frees -> no event for key 16; scan resumes normally once count < 16.
